// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all eight {a,b,c} combinations into a downstream
// 3-input combinational block, holds each for HOLD_CYCLES cycles, samples y at
// the end of each hold window, and compares the captured table against EXPECT.
module truth_table_sweeper #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter logic [7:0]  EXPECT      = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_y,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_table_out,
    output logic       o_valid,
    output logic       o_mismatch,
    output logic [3:0] o_err_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [1:0] r_state;
    logic [2:0] r_index;
    logic [7:0] r_hold;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_table;
    logic       r_valid;
    logic       r_mismatch;
    logic [3:0] r_err_count;

    logic       w_last_hold;
    logic [3:0] w_err_next;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // End-of-hold detect and error count of the captured table against EXPECT
    always_comb begin
        w_last_hold = (r_hold == HOLD_LAST);
        w_err_next  = popcount8(r_table ^ EXPECT);
    end

    // Sweep sequencer: stimulus, hold timing, capture and final comparison
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_hold      <= '0;
            r_abc       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_table     <= '0;
            r_valid     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_abc  <= '0;
                    r_busy <= 1'b0;
                    if (i_start) begin
                        r_index     <= '0;
                        r_hold      <= '0;
                        r_table     <= '0;
                        r_valid     <= 1'b0;
                        r_mismatch  <= 1'b0;
                        r_err_count <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last_hold) begin
                        r_table[r_index] <= i_y;
                        r_hold           <= '0;
                        if (r_index == 3'd7) begin
                            // Outputs are registered, so FINISH's done/busy/abc
                            // values are loaded on the edge that enters it.
                            r_abc   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_index <= r_index + 3'd1;
                            r_abc   <= r_index + 3'd1;
                        end
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                S_FINISH: begin
                    r_valid     <= 1'b1;
                    r_mismatch  <= (r_table != EXPECT);
                    r_err_count <= w_err_next;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign {o_a, o_b, o_c} = r_abc;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_table_out     = r_table;
    assign o_valid         = r_valid;
    assign o_mismatch      = r_mismatch;
    assign o_err_count     = r_err_count;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances with different hold lengths
// and expected patterns, each fed by a behavioural y lookup table.
module tb_truth_table_sweeper;

    localparam int unsigned H_OF   [3] = '{10, 10, 1};
    localparam logic [7:0]  EXP_OF [3] = '{8'hEA, 8'h00, 8'h96};

    logic       clk;
    logic [2:0] tb_rst;
    logic [2:0] tb_start;
    logic [7:0] fn [3];

    wire  [2:0] w_a, w_b, w_c, w_busy, w_done, w_valid, w_mis, w_y;
    wire  [7:0] w_tab [3];
    wire  [3:0] w_err [3];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign w_y[g] = fn[g][{w_a[g], w_b[g], w_c[g]}];
        truth_table_sweeper #(
            .HOLD_CYCLES(H_OF[g]),
            .EXPECT     (EXP_OF[g])
        ) u_dut (
            .i_clk      (clk),
            .i_reset    (tb_rst[g]),
            .i_start    (tb_start[g]),
            .i_y        (w_y[g]),
            .o_a        (w_a[g]),
            .o_b        (w_b[g]),
            .o_c        (w_c[g]),
            .o_busy     (w_busy[g]),
            .o_done     (w_done[g]),
            .o_table_out(w_tab[g]),
            .o_valid    (w_valid[g]),
            .o_mismatch (w_mis[g]),
            .o_err_count(w_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int k, input string when);
        chk($sformatf("u%0d %s abc", k, when), 32'({w_a[k], w_b[k], w_c[k]}), 32'd0);
        chk($sformatf("u%0d %s busy", k, when), 32'(w_busy[k]), 32'd0);
        chk($sformatf("u%0d %s done", k, when), 32'(w_done[k]), 32'd0);
        chk($sformatf("u%0d %s table", k, when), 32'(w_tab[k]), 32'd0);
        chk($sformatf("u%0d %s valid", k, when), 32'(w_valid[k]), 32'd0);
        chk($sformatf("u%0d %s mismatch", k, when), 32'(w_mis[k]), 32'd0);
        chk($sformatf("u%0d %s err", k, when), 32'(w_err[k]), 32'd0);
    endtask

    // Expects to be entered at a negedge with instance k idle (or with start
    // already held from a previous sweep in keep mode).
    task automatic run_sweep(input int k, input bit keep, input int ign_c, input bit ign_fin);
        int         h;
        int         last;
        logic [7:0] want;
        logic [7:0] ex;
        h    = int'(H_OF[k]);
        last = 8 * h + 1;
        want = fn[k];
        ex   = EXP_OF[k];
        tb_start[k] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            chk($sformatf("u%0d c%0d abc", k, c), 32'({w_a[k], w_b[k], w_c[k]}),
                (c < last) ? 32'((c - 1) / h) : 32'd0);
            chk($sformatf("u%0d c%0d busy", k, c), 32'(w_busy[k]), (c < last) ? 32'd1 : 32'd0);
            chk($sformatf("u%0d c%0d done", k, c), 32'(w_done[k]), (c == last) ? 32'd1 : 32'd0);
            chk($sformatf("u%0d c%0d valid", k, c), 32'(w_valid[k]), 32'd0);
            if (c == 1) begin
                chk($sformatf("u%0d c1 mismatch", k), 32'(w_mis[k]), 32'd0);
                chk($sformatf("u%0d c1 err", k), 32'(w_err[k]), 32'd0);
            end
            tb_start[k] = keep || (c == ign_c) || (ign_fin && c == last);
        end
        @(negedge clk);
        chk($sformatf("u%0d end table", k), 32'(w_tab[k]), 32'(want));
        chk($sformatf("u%0d end valid", k), 32'(w_valid[k]), 32'd1);
        chk($sformatf("u%0d end mismatch", k), 32'(w_mis[k]), (want != ex) ? 32'd1 : 32'd0);
        chk($sformatf("u%0d end err", k), 32'(w_err[k]), 32'($countones(want ^ ex)));
        chk($sformatf("u%0d end done", k), 32'(w_done[k]), 32'd0);
        chk($sformatf("u%0d end busy", k), 32'(w_busy[k]), 32'd0);
        chk($sformatf("u%0d end abc", k), 32'({w_a[k], w_b[k], w_c[k]}), 32'd0);
        tb_start[k] = keep;
    endtask

    task automatic mid_reset(input int k);
        int h;
        h = int'(H_OF[k]);
        tb_start[k] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4 * h + 1; c++) begin
            @(negedge clk);
            tb_start[k] = 1'b0;
        end
        chk($sformatf("u%0d pre-reset abc", k), 32'({w_a[k], w_b[k], w_c[k]}), 32'd4);
        tb_rst[k] = 1'b1;
        @(negedge clk);
        chk_reset(k, "midrst");
        tb_rst[k] = 1'b0;
    endtask

    initial begin
        int   k;
        int   h;
        logic ta, tb, tc;

        tb_rst   = '1;
        tb_start = '0;
        for (int i = 0; i < 3; i++) fn[i] = 8'h00;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_reset(i, "reset");
        tb_rst = '0;
        @(negedge clk);

        // y = (a & b) | c, matching EXPECT on u0, ignored starts in RUN and FINISH
        for (int i = 0; i < 8; i++) begin
            ta = ((i >> 2) & 1) != 0;
            tb = ((i >> 1) & 1) != 0;
            tc = (i & 1) != 0;
            fn[0][3'(i)] = (ta & tb) | tc;
            fn[1][3'(i)] = (ta & tb) | tc;
            fn[2][3'(i)] = ta ^ tb ^ tc;
        end
        run_sweep(0, 1'b0, 37, 1'b1);
        @(negedge clk);
        chk("u0 post-finish busy", 32'(w_busy[0]), 32'd0);

        // Same function against EXPECT = 0: five set bits differ
        run_sweep(1, 1'b0, 0, 1'b0);

        // Minimum hold with parity function
        run_sweep(2, 1'b0, 4, 1'b1);

        // Reset during index 4, then a clean full sweep
        mid_reset(0);
        @(negedge clk);
        run_sweep(0, 1'b0, 0, 1'b0);

        // Start held continuously: back-to-back sweeps on both hold lengths
        fn[2] = 8'($urandom);
        run_sweep(2, 1'b1, 0, 1'b0);
        fn[2] = 8'($urandom);
        run_sweep(2, 1'b0, 0, 1'b0);
        run_sweep(1, 1'b1, 0, 1'b0);
        fn[1] = 8'($urandom);
        run_sweep(1, 1'b0, 0, 1'b0);

        // Randomized functions, gaps and ignored start pulses
        for (int n = 0; n < 8; n++) begin
            k     = int'($urandom_range(0, 2));
            h     = int'(H_OF[k]);
            fn[k] = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_sweep(k, 1'b0, int'($urandom_range(0, 8 * h)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
